iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter REG_SIZE, default 8, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port alu_req  input  1  request strobe; sampled only in IDLE or DONE.
REQ-005 SHALL have port alu_operation  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-006 SHALL have port alu_op1  input  REG_SIZE  first operand (minuend/multiplicand/dividend).
REQ-007 SHALL have port alu_op2  input  REG_SIZE  second operand (subtrahend/multiplier/divisor).
REQ-008 SHALL have port alu_done  output  1  result valid, level.
REQ-009 SHALL have port alu_res  output  REG_SIZE  result.
REQ-010 SHALL have port alu_err  output  1  error flag, valid while alu_done=1.
REQ-011 SHALL have port busy  output  1  operation in progress, request ignored.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE; busy=1 exactly in MUL and DIV.
REQ-013 SHALL accept a request when alu_req=1 in IDLE or DONE, latching opcode and both operands that cycle; control-unit requests are single-cycle pulses and SHALL NOT need holding.
REQ-014 SHALL, on accept, clear alu_done and alu_err in the next cycle unless the result is produced that cycle.
REQ-015 SHALL, for ADD/SUB, go directly to DONE with the result registered: alu_done=1 one cycle after the accept edge.
REQ-016 SHALL compute ADD/SUB modulo 2^REG_SIZE; carry/borrow discarded; alu_err=0.
REQ-017 SHALL compute MUL as iterative shift-add, one multiplier bit per cycle, REG_SIZE iterations; alu_res = low REG_SIZE bits of product; alu_err=1 if any high product bit nonzero.
REQ-018 SHALL compute DIV as iterative restoring division, one quotient bit per cycle, REG_SIZE iterations; alu_res = unsigned quotient; alu_err=0.
REQ-019 SHALL give MUL/DIV latency REG_SIZE+1 cycles from accept edge to alu_done=1.
REQ-020 SHALL, for DIV with alu_op2=0, skip iteration, enter DONE next cycle with alu_res all ones, alu_err=1.
REQ-021 SHALL ignore alu_req while busy=1; latched operands SHALL NOT change.
REQ-022 SHALL hold alu_done=1, alu_res and alu_err stable in DONE until the next accepted request.
REQ-023 SHALL treat all operands as unsigned.

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE; alu_done=0, alu_res=0, alu_err=0, busy=0; internal accumulators cleared.
REQ-025 SHALL abort any in-flight MUL/DIV on reset with no result produced; rst has priority over alu_req in the same cycle.

Configuration
REQ-026 SHALL compile the divider in only when macro ITER_ALU_DIV_EN is defined.
REQ-027 SHALL, with ITER_ALU_DIV_EN undefined, treat DIV as 1-cycle: DONE next cycle, alu_res=0, alu_err=1; no DIV state or divider logic present.

Structure
REQ-028 SHALL place alu_op_t (2-bit opcode enum, values per REQ-005) and the state enum in shared package alu_pkg, also imported by the control unit.
REQ-029 SHALL implement the restoring division datapath (remainder/quotient registers, step logic, iteration counter) in sub-module iter_alu_div, instantiated only under ITER_ALU_DIV_EN.

Verification (REG_SIZE=8)
REQ-030 SHALL cover: ADD 200+100 -> alu_res=44, alu_err=0, alu_done 1 cycle after req; SUB 5-7 -> 254.
REQ-031 SHALL cover: MUL 13*11 -> alu_res=143, alu_err=0, done exactly 9 cycles after req; MUL 20*20 -> alu_res=144, alu_err=1.
REQ-032 SHALL cover: DIV 100/7 -> alu_res=14, done at 9 cycles; DIV 9/0 -> alu_res=255, alu_err=1, done at 1 cycle.
REQ-033 SHALL cover: ADD 1+1 pulsed during busy MUL 3*3 -> ignored, alu_res=9; back-to-back req in DONE accepted, alu_done drops for one cycle.
REQ-034 SHALL cover: rst asserted mid-MUL (cycle 4) -> next cycle alu_done=0, alu_res=0, busy=0; simultaneous rst+alu_req -> IDLE, no accept.
REQ-035 SHALL cover, ITER_ALU_DIV_EN undefined: DIV 100/7 -> alu_res=0, alu_err=1, done 1 cycle after req.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcode and control-state enums.
// Optional divider: define ITER_ALU_DIV_EN to build the DIV state and datapath.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_t;

`ifdef ITER_ALU_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b11
    } alu_state_t;
`endif

endpackage : alu_pkg

// File: rtl/iter_alu_div.sv
// Restoring divider: one quotient bit per cycle, REG_SIZE iterations.
// Only instantiated when ITER_ALU_DIV_EN is defined. The divisor is
// guaranteed non-zero by the control unit before start_i is raised.
module iter_alu_div
    import alu_pkg::*;
#(
    parameter int REG_SIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [REG_SIZE-1:0] dividend_i,
    input  logic [REG_SIZE-1:0] divisor_i,
    output logic                last_o,
    output logic [REG_SIZE-1:0] quot_o
);

    localparam int CNT_W = $clog2(REG_SIZE + 1);

    logic [REG_SIZE-1:0] rem_q, rem_d;
    logic [REG_SIZE-1:0] quo_q, quo_d;
    logic [REG_SIZE-1:0] dvs_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                active_q;

    logic [REG_SIZE:0]   shift_s;
    logic [REG_SIZE-1:0] diff_s;
    logic                ge_s;

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    always_comb begin
        shift_s = {rem_q, quo_q[REG_SIZE-1]};
        ge_s    = (shift_s >= {1'b0, dvs_q});
        diff_s  = shift_s[REG_SIZE-1:0] - dvs_q;
        if (ge_s) begin
            rem_d = diff_s;
        end else begin
            rem_d = shift_s[REG_SIZE-1:0];
        end
        quo_d  = {quo_q[REG_SIZE-2:0], ge_s};
        last_o = active_q && (cnt_q == CNT_W'(REG_SIZE - 1));
        quot_o = quo_d;
    end

    // Divider registers: load on start, iterate while active, clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q    <= {REG_SIZE{1'b0}};
            quo_q    <= {REG_SIZE{1'b0}};
            dvs_q    <= {REG_SIZE{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            active_q <= 1'b0;
        end else if (start_i) begin
            rem_q    <= {REG_SIZE{1'b0}};
            quo_q    <= dividend_i;
            dvs_q    <= divisor_i;
            cnt_q    <= {CNT_W{1'b0}};
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            active_q <= !last_o;
        end
    end

endmodule : iter_alu_div

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle ADD/SUB, shift-add MUL, optional restoring DIV.
// Optional divider: define ITER_ALU_DIV_EN; otherwise DIV returns 0 with error.
module iter_alu
    import alu_pkg::*;
#(
    parameter int REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_req,
    input  logic [1:0]          alu_operation,
    input  logic [REG_SIZE-1:0] alu_op1,
    input  logic [REG_SIZE-1:0] alu_op2,
    output logic                alu_done,
    output logic [REG_SIZE-1:0] alu_res,
    output logic                alu_err,
    output logic                busy
);

    localparam int CNT_W = $clog2(REG_SIZE + 1);

    alu_state_t state_q, state_d;
    alu_op_t    op_s;
    logic       accept_s;

    logic                done_q, done_d;
    logic [REG_SIZE-1:0] res_q, res_d;
    logic                err_q, err_d;

    // Multiplier datapath: {high, low} product with the multiplier shifting out of low.
    logic [REG_SIZE-1:0]   mcand_q;
    logic [2*REG_SIZE-1:0] prod_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [REG_SIZE:0]     mul_sum_s;
    logic [2*REG_SIZE-1:0] mul_next_s;
    logic                  mul_last_s;

    assign op_s     = alu_op_t'(alu_operation);
    assign accept_s = alu_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef ITER_ALU_DIV_EN
    logic                div_start_s;
    logic                div_last_s;
    logic [REG_SIZE-1:0] div_quot_s;

    assign div_start_s = accept_s && (op_s == OP_DIV) && (alu_op2 != {REG_SIZE{1'b0}});
    assign busy        = (state_q == ST_MUL) || (state_q == ST_DIV);

    iter_alu_div #(
        .REG_SIZE (REG_SIZE)
    ) u_div (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (div_start_s),
        .dividend_i (alu_op1),
        .divisor_i  (alu_op2),
        .last_o     (div_last_s),
        .quot_o     (div_quot_s)
    );
`else
    assign busy = (state_q == ST_MUL);
`endif

    assign alu_done = done_q;
    assign alu_res  = res_q;
    assign alu_err  = err_q;

    // Shift-add step: conditionally add the multiplicand into the high half, then shift right.
    always_comb begin
        if (prod_q[0]) begin
            mul_sum_s = {1'b0, prod_q[2*REG_SIZE-1:REG_SIZE]} + {1'b0, mcand_q};
        end else begin
            mul_sum_s = {1'b0, prod_q[2*REG_SIZE-1:REG_SIZE]};
        end
        mul_next_s = {mul_sum_s, prod_q[REG_SIZE-1:1]};
        mul_last_s = (state_q == ST_MUL) && (cnt_q == CNT_W'(REG_SIZE - 1));
    end

    // State register; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    case (op_s)
                        OP_ADD:  state_d = ST_DONE;
                        OP_SUB:  state_d = ST_DONE;
                        OP_MUL:  state_d = ST_MUL;
`ifdef ITER_ALU_DIV_EN
                        OP_DIV: begin
                            if (alu_op2 == {REG_SIZE{1'b0}}) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_DIV;
                            end
                        end
`else
                        OP_DIV:  state_d = ST_DONE;
`endif
                        default: state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
`ifdef ITER_ALU_DIV_EN
            ST_DIV: begin
                if (div_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DIV;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered result outputs.
    always_comb begin
        done_d = done_q;
        res_d  = res_q;
        err_d  = err_q;
        if (accept_s) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            case (op_s)
                OP_ADD: begin
                    done_d = 1'b1;
                    res_d  = alu_op1 + alu_op2;
                end
                OP_SUB: begin
                    done_d = 1'b1;
                    res_d  = alu_op1 - alu_op2;
                end
                OP_MUL: begin
                    done_d = 1'b0;
                end
`ifdef ITER_ALU_DIV_EN
                OP_DIV: begin
                    if (alu_op2 == {REG_SIZE{1'b0}}) begin
                        done_d = 1'b1;
                        res_d  = {REG_SIZE{1'b1}};
                        err_d  = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end
`else
                OP_DIV: begin
                    done_d = 1'b1;
                    res_d  = {REG_SIZE{1'b0}};
                    err_d  = 1'b1;
                end
`endif
                default: begin
                    done_d = 1'b0;
                end
            endcase
        end else if (mul_last_s) begin
            done_d = 1'b1;
            res_d  = mul_next_s[REG_SIZE-1:0];
            err_d  = |mul_next_s[2*REG_SIZE-1:REG_SIZE];
`ifdef ITER_ALU_DIV_EN
        end else if ((state_q == ST_DIV) && div_last_s) begin
            done_d = 1'b1;
            res_d  = div_quot_s;
            err_d  = 1'b0;
`endif
        end else begin
            done_d = done_q;
            res_d  = res_q;
            err_d  = err_q;
        end
    end

    // Result output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            res_q  <= {REG_SIZE{1'b0}};
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            res_q  <= res_d;
            err_q  <= err_d;
        end
    end

    // Multiplier registers: latch operands on accept, step once per MUL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= {REG_SIZE{1'b0}};
            prod_q  <= {(2*REG_SIZE){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else if (accept_s && (op_s == OP_MUL)) begin
            mcand_q <= alu_op1;
            prod_q  <= {{REG_SIZE{1'b0}}, alu_op2};
            cnt_q   <= {CNT_W{1'b0}};
        end else if (state_q == ST_MUL) begin
            prod_q  <= mul_next_s;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule : iter_alu

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (REG_SIZE=8) with a plain-arithmetic reference model.
module tb_iter_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_req;
    logic [1:0] alu_operation;
    logic [7:0] alu_op1, alu_op2;
    logic       alu_done;
    logic [7:0] alu_res;
    logic       alu_err;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    iter_alu #(.REG_SIZE(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_req       (alu_req),
        .alu_operation (alu_operation),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_done      (alu_done),
        .alu_res       (alu_res),
        .alu_err       (alu_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference: result, error and latency (cycles from request to visible done).
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int err, output int lat);
        int p;
        case (op)
            0: begin res = (a + b) % 256;       err = 0; lat = 1; end
            1: begin res = (a - b + 256) % 256; err = 0; lat = 1; end
            2: begin p = a * b; res = p % 256; err = (p > 255) ? 1 : 0; lat = 9; end
            default: begin
`ifdef ITER_ALU_DIV_EN
                if (b == 0) begin res = 255; err = 1; lat = 1; end
                else begin res = a / b; err = 0; lat = 9; end
`else
                res = 0; err = 1; lat = 1;
`endif
            end
        endcase
    endfunction

    // Pulse one request, then count cycles until done (bounded); operands are scrambled after the pulse.
    task automatic do_op(input int op, input int a, input int b,
                         output int res, output int err, output int lat);
        @(negedge clk);
        alu_req = 1'b1; alu_operation = 2'(op); alu_op1 = 8'(a); alu_op2 = 8'(b);
        @(posedge clk); #1;
        alu_req = 1'b0; alu_operation = 2'($urandom); alu_op1 = 8'($urandom); alu_op2 = 8'($urandom);
        lat = 1;
        while (!alu_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!alu_done) lat = -1;
        res = int'(alu_res);
        err = int'(alu_err);
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_req = 1'b0; alu_operation = 2'b00; alu_op1 = 8'h00; alu_op2 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (alu_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", alu_done); end
        vectors++; if (alu_res !== 8'h00) begin errors++; $display("FAIL reset_res got=%0d exp=0", alu_res); end
        vectors++; if (alu_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", alu_err); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        int ops[6] = '{0, 1, 2, 2, 3, 3};
        int as[6]  = '{200, 5, 13, 20, 100, 9};
        int bs[6]  = '{100, 7, 11, 20, 7, 0};
        int r, e, l, er, ee, el;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], r, e, l);
            model(ops[i], as[i], bs[i], er, ee, el);
            vectors++; if (r !== er) begin errors++; $display("FAIL dir%0d_res op=%0d %0d,%0d got=%0d exp=%0d", i, ops[i], as[i], bs[i], r, er); end
            vectors++; if (e !== ee) begin errors++; $display("FAIL dir%0d_err got=%0d exp=%0d", i, e, ee); end
            vectors++; if (l !== el) begin errors++; $display("FAIL dir%0d_lat got=%0d exp=%0d", i, l, el); end
        end
        // Result must hold steady in DONE.
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (alu_done !== 1'b1) begin errors++; $display("FAIL hold_done got=%b exp=1", alu_done); end
        vectors++; if (int'(alu_res) !== er) begin errors++; $display("FAIL hold_res got=%0d exp=%0d", alu_res, er); end
    endtask

    task automatic test_busy_ignore();
        int lat, er, ee, el;
        @(negedge clk);
        alu_req = 1'b1; alu_operation = 2'd2; alu_op1 = 8'd3; alu_op2 = 8'd3;
        @(posedge clk); #1;
        alu_req = 1'b0;
        lat = 1;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_set got=%b exp=1", busy); end
        vectors++; if (alu_done !== 1'b0) begin errors++; $display("FAIL busy_done_drop got=%b exp=0", alu_done); end
        repeat (2) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        alu_req = 1'b1; alu_operation = 2'd0; alu_op1 = 8'd1; alu_op2 = 8'd1;
        @(posedge clk); #1;
        alu_req = 1'b0; lat++;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold got=%b exp=1", busy); end
        while (!alu_done && lat < 40) begin @(posedge clk); #1; lat++; end
        model(2, 3, 3, er, ee, el);
        vectors++; if (int'(alu_res) !== er) begin errors++; $display("FAIL busy_res got=%0d exp=%0d", alu_res, er); end
        vectors++; if (int'(alu_err) !== ee) begin errors++; $display("FAIL busy_err got=%0d exp=%0d", alu_err, ee); end
        vectors++; if (lat !== el) begin errors++; $display("FAIL busy_lat got=%0d exp=%0d", lat, el); end
    endtask

    task automatic test_back_to_back();
        int r, e, l, er, ee, el;
        // MUL issued straight from DONE: done must drop right after the accept edge.
        @(negedge clk);
        alu_req = 1'b1; alu_operation = 2'd2; alu_op1 = 8'd6; alu_op2 = 8'd7;
        @(posedge clk); #1;
        alu_req = 1'b0;
        vectors++; if (alu_done !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%b exp=0", alu_done); end
        l = 1;
        while (!alu_done && l < 40) begin @(posedge clk); #1; l++; end
        model(2, 6, 7, er, ee, el);
        vectors++; if (int'(alu_res) !== er) begin errors++; $display("FAIL b2b_mul_res got=%0d exp=%0d", alu_res, er); end
        vectors++; if (l !== el) begin errors++; $display("FAIL b2b_mul_lat got=%0d exp=%0d", l, el); end
        do_op(1, 10, 3, r, e, l);
        model(1, 10, 3, er, ee, el);
        vectors++; if (r !== er) begin errors++; $display("FAIL b2b_sub_res got=%0d exp=%0d", r, er); end
        vectors++; if (l !== el) begin errors++; $display("FAIL b2b_sub_lat got=%0d exp=%0d", l, el); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        alu_req = 1'b1; alu_operation = 2'd2; alu_op1 = 8'd15; alu_op2 = 8'd15;
        @(posedge clk); #1;
        alu_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if (alu_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", alu_done); end
        vectors++; if (alu_res !== 8'h00) begin errors++; $display("FAIL rstmid_res got=%0d exp=0", alu_res); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk); rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        vectors++; if (alu_done !== 1'b0) begin errors++; $display("FAIL rstmid_noresult got=%b exp=0", alu_done); end
        @(negedge clk);
        rst = 1'b1; alu_req = 1'b1; alu_operation = 2'd0; alu_op1 = 8'd5; alu_op2 = 8'd5;
        @(posedge clk); #1;
        rst = 1'b0; alu_req = 1'b0;
        @(posedge clk); #1;
        vectors++; if (alu_done !== 1'b0) begin errors++; $display("FAIL rstreq_done got=%b exp=0", alu_done); end
        vectors++; if (alu_res !== 8'h00) begin errors++; $display("FAIL rstreq_res got=%0d exp=0", alu_res); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstreq_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        int op, a, b, r, e, l, er, ee, el;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(op, a, b, r, e, l);
            model(op, a, b, er, ee, el);
            vectors++; if (r !== er) begin errors++; $display("FAIL rnd%0d_res op=%0d %0d,%0d got=%0d exp=%0d", i, op, a, b, r, er); end
            vectors++; if (e !== ee) begin errors++; $display("FAIL rnd%0d_err op=%0d got=%0d exp=%0d", i, op, e, ee); end
            vectors++; if (l !== el) begin errors++; $display("FAIL rnd%0d_lat op=%0d got=%0d exp=%0d", i, op, l, el); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_iter_alu
